timer_dev: RTL and testbench

Programmable 32-bit down-counting timer on the CPU's device bus. It drives one bit of the coprocessor-0 hardware-interrupt vector `HWInt[5:0]`, which the top level wires as `HWInt[0]`. Software programs the timer through three word registers with load/store instructions. The timer raises a sticky interrupt request when the count expires, in either one-shot or auto-reload mode. The request stays high until software writes the timer; the CPU exception handler is the only path that acknowledges it.

---
 rtl/timer_dev.sv | 100 ++++++++++
 tb/tb_timer_dev.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/timer_dev.sv
// Programmable 32-bit down-counting timer on the device bus, driving HWInt[0].
// Three word registers (CTRL, PRESET, COUNT); sticky pend flag acknowledged by CTRL/PRESET writes.
module timer_dev (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  Addr,
    input  logic        We,
    input  logic [31:0] DIn,
    output logic [31:0] DOut,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] MODE_RELOAD = 2'b01;

    state_t      state;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        pend;

    logic ctrl_we;
    logic preset_we;
    logic expire;
    logic auto_reload;

    assign ctrl_we     = We && (Addr == ADDR_CTRL);
    assign preset_we   = We && (Addr == ADDR_PRESET);
    assign auto_reload = (ctrl[2:1] == MODE_RELOAD);
    assign expire      = (state == CNT) && ctrl[0] && (count == 32'd0);

    assign IRQ = pend & ctrl[3];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            ctrl   <= 4'd0;
            preset <= 32'd0;
            count  <= 32'd0;
            pend   <= 1'b0;
        end else begin
            if (preset_we)
                preset <= DIn;

            // A software CTRL write in INT beats the one-shot Enable auto-clear.
            if (ctrl_we)
                ctrl <= DIn[3:0];
            else if (state == INT && !auto_reload)
                ctrl[0] <= 1'b0;

            if (expire)
                pend <= 1'b1;
            else if (ctrl_we || preset_we)
                pend <= 1'b0;

            case (state)
                IDLE: begin
                    if (ctrl[0])
                        state <= LOAD;
                end
                LOAD: begin
                    count <= preset;
                    state <= CNT;
                end
                CNT: begin
                    if (!ctrl[0])
                        state <= IDLE;
                    else if (count == 32'd0)
                        state <= INT;
                    else
                        count <= count - 32'd1;
                end
                INT: begin
                    state <= auto_reload ? LOAD : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        DOut = 32'd0;
        case (Addr)
            ADDR_CTRL:   DOut = {28'd0, ctrl};
            ADDR_PRESET: DOut = preset;
            ADDR_COUNT:  DOut = count;
            default:     DOut = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: writes land on the edge of the wr() call, reads sampled #1 after edges.
// Expected values go through exp_q and are popped at each comparison point.
module tb_timer_dev;

    logic        clk;
    logic        rst;
    logic [1:0]  Addr;
    logic        We;
    logic [31:0] DIn;
    logic [31:0] DOut;
    logic        IRQ;

    logic [31:0] exp_q[$];
    int          n_vec;
    int          n_err;

    timer_dev dut (
        .clk  (clk),
        .rst  (rst),
        .Addr (Addr),
        .We   (We),
        .DIn  (DIn),
        .DOut (DOut),
        .IRQ  (IRQ)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        Addr = a;
        DIn  = d;
        We   = 1'b1;
        tick();
        We   = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp_val);
        logic [31:0] got;
        logic [31:0] want;
        Addr = a;
        exp_q.push_back(exp_val);
        #1;
        got  = DOut;
        want = exp_q.pop_front();
        n_vec++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: DOut=%h expected %h", tag, got, want);
        end
    endtask

    task automatic chk_irq(input string tag, input logic exp_val);
        logic [31:0] got;
        logic [31:0] want;
        exp_q.push_back({31'd0, exp_val});
        #1;
        got  = {31'd0, IRQ};
        want = exp_q.pop_front();
        n_vec++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: IRQ=%0d expected %0d", tag, got, want);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b0;
        Addr  = 2'd0;
        We    = 1'b0;
        DIn   = 32'd0;

        // Reset state
        repeat (3) tick();
        chk_irq("rst_hold_irq", 1'b0);
        rst = 1'b1;
        tick();
        chk_reg("rst_ctrl", 2'd0, 32'd0);
        chk_reg("rst_preset", 2'd1, 32'd0);
        chk_reg("rst_count", 2'd2, 32'd0);
        chk_reg("rst_rsvd", 2'd3, 32'd0);
        chk_irq("rst_irq", 1'b0);

        // One-shot, PRESET=3, CTRL=0x9 at edge k
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h9);
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_reg("os_count", 2'd2, 32'd3 - 32'(i));
        end
        chk_irq("os_irq_pre", 1'b0);
        tick();
        chk_irq("os_irq_rise", 1'b1);
        chk_reg("os_ctrl_int", 2'd0, 32'h9);
        tick();
        chk_reg("os_ctrl_clr", 2'd0, 32'h8);
        repeat (3) tick();
        chk_irq("os_irq_sticky", 1'b1);
        wr(2'd0, 32'h8);
        chk_irq("os_irq_ack", 1'b0);

        // Auto-reload, PRESET=5, CTRL=0xB at edge k; period 8
        wr(2'd1, 32'd5);
        wr(2'd0, 32'hB);
        repeat (7) tick();
        chk_irq("ar_pre0", 1'b0);
        chk_reg("ar_count0", 2'd2, 32'd0);
        tick();
        chk_irq("ar_irq0", 1'b1);
        wr(2'd0, 32'hB);
        chk_irq("ar_ack0", 1'b0);
        tick();
        chk_reg("ar_reload0", 2'd2, 32'd5);
        repeat (5) tick();
        chk_irq("ar_pre1", 1'b0);
        tick();
        chk_irq("ar_irq1", 1'b1);
        wr(2'd0, 32'hB);
        chk_irq("ar_ack1", 1'b0);
        tick();
        chk_reg("ar_reload1", 2'd2, 32'd5);
        repeat (5) tick();
        chk_irq("ar_pre2", 1'b0);
        tick();
        chk_irq("ar_irq2", 1'b1);
        wr(2'd0, 32'h0);
        repeat (3) tick();

        // Masked expiry, then acknowledging write raises nothing
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        repeat (6) tick();
        chk_irq("mask_irq", 1'b0);
        chk_reg("mask_ctrl_clr", 2'd0, 32'h0);
        wr(2'd0, 32'h8);
        chk_irq("mask_ack_irq", 1'b0);

        // Expiry coinciding with a CTRL write: set wins
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h9);
        repeat (4) tick();
        chk_irq("coinc_pre", 1'b0);
        wr(2'd0, 32'h9);
        chk_irq("coinc_irq", 1'b1);
        // Enable write in INT overrides one-shot clear and restarts
        wr(2'd0, 32'h9);
        chk_irq("int_wr_ack", 1'b0);
        chk_reg("int_wr_ctrl", 2'd0, 32'h9);
        repeat (2) tick();
        chk_reg("int_wr_reload", 2'd2, 32'd2);
        wr(2'd0, 32'h0);
        repeat (3) tick();

        // Pause at COUNT=40, ignored writes, re-enable reloads PRESET
        wr(2'd1, 32'd50);
        wr(2'd0, 32'h1);
        repeat (11) tick();
        wr(2'd0, 32'h0);
        repeat (4) tick();
        chk_reg("pause_count", 2'd2, 32'd40);
        chk_reg("pause_ctrl", 2'd0, 32'h0);
        wr(2'd2, 32'h1234);
        chk_reg("count_wr_ignored", 2'd2, 32'd40);
        wr(2'd3, 32'hFFFF_FFFF);
        chk_reg("rsvd_read", 2'd3, 32'd0);
        chk_reg("rsvd_ctrl", 2'd0, 32'h0);
        chk_reg("rsvd_preset", 2'd1, 32'd50);
        wr(2'd1, 32'd7);
        wr(2'd0, 32'h1);
        tick();
        chk_reg("resume_hold", 2'd2, 32'd40);
        tick();
        chk_reg("resume_reload", 2'd2, 32'd7);
        wr(2'd0, 32'h0);
        repeat (3) tick();

        // PRESET=0: IRQ 3 edges after the Enable write, then async reset
        wr(2'd1, 32'd0);
        wr(2'd0, 32'hB);
        repeat (2) tick();
        chk_irq("p0_pre", 1'b0);
        tick();
        chk_irq("p0_irq", 1'b1);
        rst = 1'b0;
        #1;
        chk_irq("rst_mid_irq", 1'b0);
        chk_reg("rst_mid_ctrl", 2'd0, 32'h0);
        rst = 1'b1;
        tick();

        // Full-range PRESET, then reset mid-count
        wr(2'd1, 32'hFFFF_FFFF);
        wr(2'd0, 32'h1);
        repeat (2) tick();
        chk_reg("full_load", 2'd2, 32'hFFFF_FFFF);
        tick();
        chk_reg("full_dec1", 2'd2, 32'hFFFF_FFFE);
        repeat (3) tick();
        chk_reg("full_dec4", 2'd2, 32'hFFFF_FFFB);
        chk_irq("full_irq", 1'b0);
        rst = 1'b0;
        #1;
        chk_reg("rst_mid_count", 2'd2, 32'd0);
        chk_reg("rst_mid_preset", 2'd1, 32'd0);
        rst = 1'b1;
        repeat (3) tick();
        chk_reg("post_rst_count", 2'd2, 32'd0);
        chk_irq("post_rst_irq", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
